// File: rtl/vmx_pkg.sv
// Shared definitions for the memory-mapped vector-matrix engine:
// FSM state encoding and the bit positions of the ctrl and flag registers.
package vmx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    ROW,
    WR,
    DONE
  } state_e;

  localparam int CTRL_START  = 1;
  localparam int CTRL_SIGNED = 2;
  localparam int CTRL_RELU   = 3;

  localparam int FLAG_BUSY = 0;
  localparam int FLAG_DONE = 1;
  localparam int FLAG_SAT  = 2;

endpackage

// File: rtl/vmx_dot_sat.sv
// Combinational N-lane dot product of two memory words with clamping of the
// full-precision sum to OW bits in either signed or unsigned mode.
module vmx_dot_sat #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int OW = 2 * DW
) (
  input  logic [N*DW-1:0] x_i,
  input  logic [N*DW-1:0] row_i,
  input  logic            signed_i,
  output logic [OW-1:0]   res_o,
  output logic            sat_o
);

  localparam int AccW = OW + $clog2(N);
  // One spare bit keeps an all-ones unsigned sum positive in a signed register.
  localparam int SumW = AccW + 1;

  logic signed [SumW-1:0]   acc;
  logic signed [2*DW+1:0]   prod;
  logic        [SumW-OW:0]  hi_s;
  logic        [SumW-OW-1:0] hi_u;

  function automatic logic signed [DW:0] ext(input logic [DW-1:0] v, input logic s);
    return $signed({s & v[DW-1], v});
  endfunction

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int i = 0; i < N; i++) begin
      prod = ext(x_i[i*DW +: DW], signed_i) * ext(row_i[i*DW +: DW], signed_i);
      acc  = acc + SumW'(prod);
    end
  end

  assign hi_s = acc[SumW-1:OW-1];
  assign hi_u = acc[SumW-1:OW];

  always_comb begin
    res_o = acc[OW-1:0];
    sat_o = 1'b0;
    if (signed_i) begin
      if (!((&hi_s) || (~|hi_s))) begin
        sat_o = 1'b1;
        res_o = acc[SumW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
    end else if (|hi_u) begin
      sat_o = 1'b1;
      res_o = '1;
    end
  end

endmodule

// File: rtl/vmx_mm_engine.sv
// Vector-matrix engine: reads x and N matrix rows from scratch memory,
// computes y = M*x with saturation/ReLU, and writes y back as two words.
module vmx_mm_engine
  import vmx_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ctrl,
  input  logic [AW-1:0]   rbase_addr,
  input  logic [AW-1:0]   wbase_addr,
  output logic [AW-1:0]   addr,
  output logic            wr_en,
  input  logic [N*DW-1:0] d_i,
  output logic [N*DW-1:0] d_o,
  output logic [31:0]     flag
);

  localparam int OW   = 2 * DW;
  localparam int RW   = $clog2(N);
  localparam int HALF = N / 2;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   rbase_q, rbase_d, wbase_q, wbase_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_en_q, wr_en_d;
  logic [N*DW-1:0] d_o_q, d_o_d;
  logic            signed_q, signed_d, relu_q, relu_d;
  logic            busy_q, busy_d, done_q, done_d, sat_q, sat_d;
  logic            start_prev_q;
  logic [N*DW-1:0] x_q;
  logic [OW-1:0]   res_q [N];

  logic            start_edge;
  logic [OW-1:0]   dot_res, row_res;
  logic            dot_sat;
  logic            ctrl_unused;

  assign ctrl_unused = ^{ctrl[31:4], ctrl[0]};
  assign start_edge  = ctrl[CTRL_START] & ~start_prev_q;

  vmx_dot_sat #(.N(N), .DW(DW), .OW(OW)) u_dot (
    .x_i      (x_q),
    .row_i    (d_i),
    .signed_i (signed_q),
    .res_o    (dot_res),
    .sat_o    (dot_sat)
  );

  assign row_res = (relu_q && signed_q && dot_res[OW-1]) ? '0 : dot_res;

  // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    wr_d     = wr_q;
    rbase_d  = rbase_q;
    wbase_d  = wbase_q;
    addr_d   = addr_q;
    wr_en_d  = 1'b0;
    d_o_d    = '0;
    signed_d = signed_q;
    relu_d   = relu_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sat_d    = sat_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          state_d  = LOAD_X;
          addr_d   = rbase_addr;
          rbase_d  = rbase_addr;
          wbase_d  = wbase_addr;
          signed_d = ctrl[CTRL_SIGNED];
          relu_d   = ctrl[CTRL_RELU];
          busy_d   = 1'b1;
          done_d   = 1'b0;
          sat_d    = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      LOAD_X: begin
        state_d = ROW;
        row_d   = '0;
        addr_d  = rbase_q + AW'(1);
      end
      ROW: begin
        if (dot_sat) sat_d = 1'b1;
        if (row_q == RW'(N - 1)) begin
          state_d = WR;
          wr_d    = 1'b0;
          addr_d  = wbase_q;
          wr_en_d = 1'b1;
          for (int j = 0; j < HALF; j++) d_o_d[j*OW +: OW] = res_q[j];
        end else begin
          row_d  = row_q + RW'(1);
          addr_d = rbase_q + AW'(row_q) + AW'(2);
        end
      end
      WR: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = wbase_q + AW'(1);
          wr_en_d = 1'b1;
          // Row N-1 finishes one cycle before this word is registered.
          for (int j = 0; j < HALF; j++) d_o_d[j*OW +: OW] = res_q[HALF+j];
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      wr_q         <= 1'b0;
      rbase_q      <= '0;
      wbase_q      <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      d_o_q        <= '0;
      signed_q     <= 1'b0;
      relu_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      wr_q         <= wr_d;
      rbase_q      <= rbase_d;
      wbase_q      <= wbase_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      d_o_q        <= d_o_d;
      signed_q     <= signed_d;
      relu_q       <= relu_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sat_q        <= sat_d;
      start_prev_q <= ctrl[CTRL_START];
    end
  end

  // NOTE: x and the result buffer are pure datapath storage, always written before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_X) x_q <= d_i;
    if (state_q == ROW) res_q[row_q] <= row_res;
  end

  assign addr  = addr_q;
  assign wr_en = wr_en_q;
  assign d_o   = d_o_q;

  always_comb begin
    flag            = '0;
    flag[FLAG_BUSY] = busy_q;
    flag[FLAG_DONE] = done_q;
    flag[FLAG_SAT]  = sat_q;
  end

endmodule

// File: doc/vmx_mm_engine.md
Name: vmx_mm_engine

Overview:
Parametrised successor to the fixed 4-lane memory-mapped vector-matrix unit. It computes y = M·x, where x and M are N-lane vectors of DW-bit elements stored in a single-port, word-wide memory. It adds signed/unsigned modes, ReLU, saturating accumulation, and start-edge detection. It sits between the control-register block (ctrl/flag) and the local scratch memory, and drives that memory's address, write-enable and write data.

Parameters:
N, 4, lanes per memory word and matrix rows/cols; even, >= 2
DW, 16, element width in bits
AW, 8, memory address width
OW, 2*DW, result lane width (derived localparam, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ctrl  in  32  [1] start (rising edge), [2] signed mode, [3] relu enable, others ignored
rbase_addr  in  AW  word address of x; matrix row r is at rbase_addr+1+r
wbase_addr  in  AW  word address of first result word
addr  out  AW  memory address
wr_en  out  1  memory write strobe, one word per cycle
d_i  in  N*DW  memory read data, combinational (same-cycle) read of addr
d_o  out  N*DW  memory write data
flag  out  32  [0] busy, [1] done (sticky), [2] sat (sticky), others 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE; addr=0, wr_en=0, d_o=0, flag=0; start-edge register cleared.
- Lane i of any word occupies bits [i*DW +: DW]. Result lane r occupies [(r mod N/2)*OW +: OW] of its word.
- Start is detected when ctrl[1] is 1 this cycle and was 0 last cycle. A start is ignored while busy.
- On an accepted start, latch rbase_addr, wbase_addr, ctrl[2] and ctrl[3]. Clear done and sat. Set busy.
- addr, wr_en and d_o are registered. They hold the current state's values for the whole cycle.
- FSM:
  - IDLE: waits for start.
  - LOAD_X: addr=rbase; captures x from d_i at end of cycle.
  - ROW(r), r=0..N-1: addr=rbase+1+r; computes the dot product of d_i and x and stores saturated lane r in the result buffer.
  - WR(k), k=0..1: addr=wbase+k, wr_en=1, d_o = lanes k*N/2 .. k*N/2+N/2-1.
  - DONE: busy=0, done=1; returns to IDLE.
- Latency: start edge sampled at edge 0. LOAD_X runs in cycle 1, ROW r in cycle 2+r, WR0 in cycle N+2, WR1 in cycle N+3. done is visible from cycle N+4. Total is N+4 cycles (8 for N=4).
- Arithmetic:
  - Products are DW x DW, sign- or zero-extended per the latched mode.
  - The accumulator is OW+clog2(N) bits wide and is not truncated mid-sum.
  - Saturation to OW bits: signed clamps to [-2^(OW-1), 2^(OW-1)-1]; unsigned clamps to 2^OW-1.
  - Any clamp sets sat, which stays set until the next accepted start.
  - ReLU applies after saturation, in signed mode only: negative results become 0. In unsigned mode it has no effect.
- Addresses wrap modulo 2^AW, e.g. rbase=8'hFE reads FE, FF, 00, ...
- Only WR states assert wr_en. No write occurs in any other state or after reset.
- Reset mid-operation returns to IDLE immediately. Remaining writes are not issued; flag clears.
- ctrl, rbase_addr and wbase_addr changes after an accepted start have no effect until DONE.

Decomposition:
- Package vmx_pkg: state enum (IDLE, LOAD_X, ROW, WR, DONE), ctrl bit indices (START=1, SIGNED=2, RELU=3), flag bit indices (BUSY=0, DONE=1, SAT=2).
- One sub-module, vmx_dot_sat:
  - inputs: N-lane x and row vectors, signed-mode flag;
  - outputs: saturated OW-bit result and a sat indication;
  - purely combinational.
- The FSM, buffers and memory interface live in the top module.

Test Plan:
- Unsigned, N=4, DW=16, rbase=0, wbase=8, with these words:
  - mem[0]={1,2,3,4};
  - mem[1]={5,6,7,8}, mem[2]={4,3,2,1}, mem[3]={8,7,6,5}, mem[4]={1,2,3,4};
  - pulse ctrl[1] one cycle.
  - Expected: mem[8]={32'd20,32'd70}, mem[9]={32'd30,32'd60}; wr_en high exactly 2 cycles; done at cycle 8; sat=0.
- Signed: x lane0=16'hFFFF, row0 lane0=2, all other data 0, ctrl[2]=1 -> y0=32'hFFFFFFFE. Same data with ctrl[3]=1 -> y0=0. Same data unsigned -> y0=32'h0001FFFE.
- Saturation, unsigned: all elements 16'hFFFF -> every lane 32'hFFFFFFFF, sat=1. Signed with all elements 16'h8000 -> every lane 32'h7FFFFFFF, sat=1.
- Start handling:
  - ctrl[1] held high 5 cycles -> exactly one operation, 2 writes.
  - A second rising edge while busy is ignored.
  - A new edge after done -> done and sat clear, new run.
- Wrap: rbase=8'hFE, wbase=8'hFF -> reads FE, FF, 00, 01, 02; writes FF then 00.
- Reset: rst asserted during ROW(1) -> next cycle flag=0, wr_en=0; no writes to wbase; a later start runs normally.
